// File: rtl/latch_cfg_sequencer.sv
// AXI4-Lite master that writes a configuration vector into the Latch_v3 register bank,
// reads every word back and reports the result. Optional watchdog: LATCH_SEQ_TIMEOUT_EN.
module latch_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_TIMEOUT          = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [C_NUM_REGS*32-1:0]        cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

    state_t      state, next_state;
    logic [3:0]  idx, next_idx;
    logic [1:0]  next_err_code;
    logic [3:0]  next_err_index;
    logic        aw_done, w_done;
    logic        load_shadow;
    logic [31:0] shadow [C_NUM_REGS];
    logic [31:0] cur_word;
    logic        last_idx;
    logic        active;
    logic        tmo_hit;
    logic        idle_drain;

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == 4'(i)) cur_word = shadow[i];
        end
    end

    assign last_idx = (idx == 4'(C_NUM_REGS - 1));
    assign active   = (state == WR_REQ) || (state == WR_RESP) ||
                      (state == RD_REQ) || (state == RD_RESP);

`ifdef LATCH_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(C_TIMEOUT + 1);
    logic [TMR_W-1:0] timer;
    logic             late_ok;

    // Timer restarts on every state change so each handshake gets its own budget.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            timer   <= '0;
            late_ok <= 1'b0;
        end else begin
            if (next_state != state) timer <= '0;
            else if (active)         timer <= timer + 1'b1;
            if (state == IDLE && start) late_ok <= 1'b0;
            else if (tmo_hit)           late_ok <= 1'b1;
        end
    end

    assign tmo_hit    = active && (timer == TMR_W'(C_TIMEOUT - 1));
    assign idle_drain = (state == IDLE) && late_ok;
`else
    logic unused_timeout;
    assign unused_timeout = (C_TIMEOUT > 0);
    assign tmo_hit        = 1'b0;
    assign idle_drain     = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            idx       <= '0;
            err_code  <= '0;
            err_index <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            state     <= next_state;
            idx       <= next_idx;
            err_code  <= next_err_code;
            err_index <= next_err_index;
            if (state == WR_REQ && next_state == WR_REQ) begin
                aw_done <= aw_done | M_AXI_AWREADY;
                w_done  <= w_done | M_AXI_WREADY;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (load_shadow) begin
            for (int i = 0; i < C_NUM_REGS; i++) shadow[i] <= cfg_data[32*i +: 32];
        end
    end

    always_comb begin
        next_state     = state;
        next_idx       = idx;
        next_err_code  = err_code;
        next_err_index = err_index;
        load_shadow    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_shadow    = 1'b1;
                    next_idx       = '0;
                    next_err_code  = 2'b00;
                    next_err_index = '0;
                    next_state     = WR_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) next_state = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        next_err_code  = 2'b01;
                        next_err_index = idx;
                        next_state     = FINISH;
                    end else if (last_idx) begin
                        next_idx   = '0;
                        next_state = RD_REQ;
                    end else begin
                        next_idx   = idx + 4'd1;
                        next_state = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) next_state = RD_RESP;
            end
            RD_RESP: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != cur_word) begin
                        next_err_code  = (M_AXI_RRESP != 2'b00) ? 2'b01 : 2'b10;
                        next_err_index = idx;
                        next_state     = FINISH;
                    end else if (last_idx) begin
                        next_state = FINISH;
                    end else begin
                        next_idx   = idx + 4'd1;
                        next_state = RD_REQ;
                    end
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (tmo_hit) begin
            next_err_code  = 2'b11;
            next_err_index = idx;
            next_state     = FINISH;
        end
    end

    assign busy          = active;
    assign done          = (state == FINISH);
    assign error         = (err_code != 2'b00);
    assign M_AXI_AWADDR  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
    assign M_AXI_ARADDR  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WDATA   = cur_word;
    assign M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
    assign M_AXI_WVALID  = (state == WR_REQ) && !w_done;
    assign M_AXI_BREADY  = (state == WR_RESP) || idle_drain;
    assign M_AXI_ARVALID = (state == RD_REQ);
    assign M_AXI_RREADY  = (state == RD_RESP) || idle_drain;

endmodule

// File: tb/tb_latch_cfg_sequencer.sv
// Scoreboard bench for latch_cfg_sequencer: behavioural latch slave, reference model of the
// expected outcome per sequence, and a done-triggered monitor that pops and compares.
module tb_latch_cfg_sequencer;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic           busy, done, error;
    logic [1:0]     err_code;
    logic [3:0]     err_index;
    logic [31:0]    awaddr, wdata, araddr, rdata;
    logic [2:0]     awprot, arprot;
    logic [3:0]     wstrb;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [1:0]     bresp, rresp;

    latch_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_NUM_REGS(N),
        .C_BASE_ADDR(32'h0000_0000), .C_TIMEOUT(TMO)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: mode 0 zero-wait, 1 random readies, 2 W accepted ahead of AW, 3 AR never accepted.
    int          slv_mode = 0;
    int          slv_err_idx = -1;
    int          slv_stuck_idx = -1;
    logic        aw_rnd, w_rnd, ar_rnd;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    int          w_age;
    logic [31:0] slv_mem [N] = '{default: 32'h0};
    logic [15:0] slv_wr_cnt [N] = '{default: 16'h0};
    int          slv_rd_cnt = 0;
    int          slv_bad_cnt = 0;
    logic        aw_en, w_en, ar_en, aw_hs, w_hs, ar_hs;
    logic [31:0] wr_a, wr_d;
    int          wr_i, rd_i;

    assign aw_en   = (slv_mode == 1) ? aw_rnd : (slv_mode == 2) ? (w_got && w_age >= 3) : 1'b1;
    assign w_en    = (slv_mode == 1) ? w_rnd : 1'b1;
    assign ar_en   = (slv_mode == 1) ? ar_rnd : (slv_mode == 3) ? 1'b0 : 1'b1;
    assign awready = aw_en && !aw_got && !bvalid;
    assign wready  = w_en && !w_got && !bvalid;
    assign arready = ar_en && !rvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_a    = aw_hs ? awaddr : aw_addr_q;
    assign wr_d    = w_hs ? wdata : w_data_q;
    assign wr_i    = int'(wr_a >> 2);
    assign rd_i    = int'(araddr >> 2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0; w_age <= 0;
            aw_rnd <= 1'b0; w_rnd <= 1'b0; ar_rnd <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0;
        end else begin
            aw_rnd <= 1'($urandom_range(0, 1));
            w_rnd  <= 1'($urandom_range(0, 1));
            ar_rnd <= 1'($urandom_range(0, 1));
            w_age  <= w_got ? w_age + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bvalid <= 1'b1;
                if (wr_i < N) begin
                    slv_wr_cnt[wr_i] <= slv_wr_cnt[wr_i] + 16'd1;
                    slv_mem[wr_i]    <= (wr_i == slv_stuck_idx) ? 32'h0 : wr_d;
                    bresp            <= (wr_i == slv_err_idx) ? 2'b10 : 2'b00;
                end else begin
                    slv_bad_cnt <= slv_bad_cnt + 1;
                    bresp       <= 2'b11;
                end
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
                if (w_hs)  begin w_got <= 1'b1;  w_data_q <= wdata;   end
            end
            if (ar_hs) begin
                rvalid     <= 1'b1;
                slv_rd_cnt <= slv_rd_cnt + 1;
                rdata      <= (rd_i < N) ? slv_mem[rd_i] : 32'hDEAD_BEEF;
                rresp      <= (rd_i < N) ? 2'b00 : 2'b11;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [1:0]       code;
        logic [3:0]       index;
        int               lat;
        int               wr_n;
        int               rd_n;
        int               stuck;
        logic [N*32-1:0]  words;
        logic [N-1:0][15:0] wr_base;
        int               rd_base;
        int               start_cyc;
    } exp_t;

    exp_t sb_q[$];

    // Outcome of one sequence from the rules: write all, stop on the first write error,
    // else read all and stop on the first word that does not come back as written.
    function automatic exp_t refModel(input logic [N*32-1:0] words, input int err_idx,
                                      input int stuck_idx, input bit tmo);
        exp_t e;
        logic [31:0] w, rb;
        e.code = 2'b00; e.index = 4'd0; e.lat = 0; e.words = words; e.stuck = stuck_idx;
        e.wr_n = N; e.rd_n = N; e.wr_base = '0; e.rd_base = 0; e.start_cyc = 0;
        if (err_idx >= 0) begin
            e.code = 2'b01; e.index = 4'(err_idx); e.wr_n = err_idx + 1; e.rd_n = 0;
            return e;
        end
        if (tmo) begin
            e.code = 2'b11; e.index = 4'd0; e.rd_n = 0;
            return e;
        end
        for (int i = 0; i < N; i++) begin
            w  = words[32*i +: 32];
            rb = (i == stuck_idx) ? 32'h0 : w;
            if (rb != w) begin
                e.code = 2'b10; e.index = 4'(i); e.rd_n = i + 1;
                return e;
            end
        end
        return e;
    endfunction

    // Caller is at a negedge; start is held for exactly one cycle.
    task automatic applyStimulus(input logic [N*32-1:0] words, input int mode,
                                 input int err_idx, input int stuck_idx);
        exp_t e;
        slv_mode = mode; slv_err_idx = err_idx; slv_stuck_idx = stuck_idx;
        cfg_data = words;
        e = refModel(words, err_idx, stuck_idx, mode == 3);
        // Inclusive count from the start cycle to the done cycle: 2 cycles per transaction + 2.
        if (mode == 0)      e.lat = 2 + 2 * e.wr_n + 2 * e.rd_n;
        else if (mode == 3) e.lat = 2 + 2 * N + TMO;
        for (int i = 0; i < N; i++) e.wr_base[i] = slv_wr_cnt[i];
        e.rd_base   = slv_rd_cnt;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseStart(input logic [N*32-1:0] words);
        cfg_data = words;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) checkOutput("done_within_budget", 32'd0, 32'd1);
    endtask

    function automatic logic [N*32-1:0] randWords();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [31:0] w;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("error", 32'(error), 32'(e.code != 2'b00));
                checkOutput("err_code", 32'(err_code), 32'(e.code));
                checkOutput("err_index", 32'(err_index), 32'(e.index));
                if (e.lat > 0) checkOutput("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                for (int i = 0; i < N; i++) begin
                    checkOutput($sformatf("wr_count[%0d]", i),
                                32'(slv_wr_cnt[i] - e.wr_base[i]), 32'(i < e.wr_n));
                    if (i < e.wr_n) begin
                        w = e.words[32*i +: 32];
                        checkOutput($sformatf("wr_data[%0d]", i), slv_mem[i],
                                    (i == e.stuck) ? 32'h0 : w);
                    end
                end
                checkOutput("rd_count", 32'(slv_rd_cnt - e.rd_base), 32'(e.rd_n));
                checkOutput("valids_at_done", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_watchdog: got expired expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valids", {28'd0, awvalid, wvalid, arvalid, 1'b0}, 32'd0);
        checkOutput("rst_readies", {30'd0, bready, rready}, 32'd0);
        checkOutput("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        checkOutput("rst_err_index", 32'(err_index), 32'd0);
        checkOutput("rst_wstrb", 32'(wstrb), 32'hF);
        checkOutput("rst_prot", {26'd0, awprot, arprot}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] zero-wait load of 1,2,3,4");
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1}, 0, -1, -1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        waitDone(200);
        @(negedge clk);

        $display("[TB] W accepted ahead of AW");
        applyStimulus(randWords(), 2, -1, -1);
        waitDone(400);
        @(negedge clk);

        $display("[TB] SLVERR on register 2");
        applyStimulus(randWords(), 0, 2, -1);
        waitDone(200);
        @(negedge clk);

        $display("[TB] register 1 stuck at zero");
        applyStimulus({32'h4, 32'h3, 32'h2, 32'h1}, 0, -1, 1);
        waitDone(200);
        @(negedge clk);

        $display("[TB] start and cfg_data change while busy");
        applyStimulus(randWords(), 0, -1, -1);
        repeat (3) @(negedge clk);
        pulseStart(randWords());
        cfg_data = randWords();
        waitDone(200);
        @(negedge clk);

        $display("[TB] start coincident with done, then the cycle after");
        applyStimulus(randWords(), 0, 0, -1);
        waitDone(200);
        cfg_data = randWords();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("error_held_after_ignored_start", 32'(error), 32'd1);
        checkOutput("busy_after_ignored_start", 32'(busy), 32'd0);
        applyStimulus(randWords(), 0, -1, -1);
        checkOutput("busy_new_sequence", 32'(busy), 32'd1);
        checkOutput("error_cleared_by_start", 32'(error), 32'd0);
        waitDone(200);
        @(negedge clk);

        $display("[TB] randomized sequences");
        for (int t = 0; t < 8; t++) begin
            applyStimulus(randWords(), int'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
            waitDone(600);
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] reset mid-transaction");
        slv_mode = 1; slv_err_idx = -1; slv_stuck_idx = -1;
        pulseStart(randWords());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(randWords(), 0, -1, -1);
        waitDone(200);
        @(negedge clk);

`ifdef LATCH_SEQ_TIMEOUT_EN
        $display("[TB] AR never accepted, watchdog");
        applyStimulus(randWords(), 3, -1, -1);
        waitDone(200);
        @(negedge clk);
        checkOutput("idle_drain_readies", {30'd0, bready, rready}, 32'd3);
`endif

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("out_of_range_writes", 32'(slv_bad_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
